// File: rtl/ball_pkg.sv
// rtl/ball_pkg.sv - shared constants, state encoding and launch trig tables for ball_flight
package ball_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_LANDED = 2'd2
    } state_t;

    localparam logic [9:0] START_X   = 10'd31;
    localparam logic [8:0] GROUND_Y  = 9'd425;
    localparam logic [9:0] RIGHT_X   = 10'd635;
    localparam int         BALL_SIZE = 5;
    localparam logic [4:0] ANG_MAX   = 5'd16;

    // round(15*sin(a*5.625 deg)) and round(15*cos(a*5.625 deg)), a = 0..16
    localparam logic [3:0] SIN_TABLE [0:16] = '{
        4'd0,  4'd1,  4'd3,  4'd4,  4'd6,  4'd7,  4'd8,  4'd10, 4'd11,
        4'd12, 4'd12, 4'd13, 4'd14, 4'd14, 4'd15, 4'd15, 4'd15
    };
    localparam logic [3:0] COS_TABLE [0:16] = '{
        4'd15, 4'd15, 4'd15, 4'd14, 4'd14, 4'd13, 4'd12, 4'd12, 4'd11,
        4'd10, 4'd8,  4'd7,  4'd6,  4'd4,  4'd3,  4'd1,  4'd0
    };

endpackage

// File: rtl/ball_flight_launch_vector.sv
// rtl/ball_flight_launch_vector.sv - combinational aim (Ang/Vel) to launch velocity (vx, vy)
module launch_vector
    import ball_pkg::*;
(
    input  logic [4:0] Ang,
    input  logic [2:0] Vel,
    output logic [4:0] vx,
    output logic [4:0] vy
);

    logic [4:0] ang_idx;
    logic [7:0] mag;
    logic [7:0] vx_full;
    logic [7:0] vy_full;

    always_comb begin
        ang_idx = (Ang > ANG_MAX) ? ANG_MAX : Ang;
        mag     = {5'd0, Vel} + 8'd1;
        vx_full = 8'(COS_TABLE[ang_idx]) * mag;
        vy_full = 8'(SIN_TABLE[ang_idx]) * mag;
        vx      = 5'(vx_full >> 2);
        vy      = 5'(vy_full >> 2);
    end

endmodule

// File: rtl/ball_flight.sv
// rtl/ball_flight.sv - launched-ball trajectory: launch on press, integrate per frame tick, stop at ground or right wall
module ball_flight #(
    parameter logic [9:0] START_X  = ball_pkg::START_X,
    parameter logic [8:0] GROUND_Y = ball_pkg::GROUND_Y,
    parameter logic [9:0] RIGHT_X  = ball_pkg::RIGHT_X
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       launch,
    input  logic       update,
    input  logic [2:0] Vel,
    input  logic [4:0] Ang,
    input  logic [9:0] xCount,
    input  logic [9:0] yCount,
    output logic [9:0] ballX,
    output logic [8:0] ballY,
    output logic       ball,
    output logic       busy,
    output logic       landed
);

    localparam logic [10:0] SPAN = 11'(ball_pkg::BALL_SIZE - 1);

    ball_pkg::state_t   state, state_n;
    logic               launch_q;
    logic               press;
    logic signed [10:0] y, y_n;
    logic [9:0]         x_n;
    logic [4:0]         vx, vx_n;
    logic signed [7:0]  vy, vy_n;
    logic [4:0]         lv_vx, lv_vy;
    logic [10:0]        x_step;
    logic signed [10:0] y_step;
    logic               hit;

    launch_vector u_launch_vector (
        .Ang (Ang),
        .Vel (Vel),
        .vx  (lv_vx),
        .vy  (lv_vy)
    );

    assign press  = launch_q & ~launch;
    assign ballY  = y[8:0];
    assign busy   = (state == ball_pkg::ST_FLIGHT);
    assign landed = (state == ball_pkg::ST_LANDED);

    always_comb begin
        state_n = state;
        x_n     = ballX;
        y_n     = y;
        vx_n    = vx;
        vy_n    = vy;
        x_step  = {1'b0, ballX} + {6'd0, vx};
        y_step  = y - {{3{vy[7]}}, vy};
        case (state)
            ball_pkg::ST_IDLE, ball_pkg::ST_LANDED: begin
                // A press wins over a coincident update: motion starts on the next tick
                if (press) begin
                    vx_n    = lv_vx;
                    vy_n    = {3'd0, lv_vy};
                    x_n     = START_X;
                    y_n     = {2'b00, GROUND_Y};
                    state_n = ball_pkg::ST_FLIGHT;
                end
            end
            ball_pkg::ST_FLIGHT: begin
                if (update) begin
                    x_n  = x_step[9:0];
                    y_n  = y_step;
                    vy_n = vy - 8'sd1;
                    if (y_step >= $signed({2'b00, GROUND_Y})) begin
                        y_n     = {2'b00, GROUND_Y};
                        state_n = ball_pkg::ST_LANDED;
                    end
                    if (x_step >= {1'b0, RIGHT_X}) begin
                        x_n     = RIGHT_X;
                        state_n = ball_pkg::ST_LANDED;
                    end
                end
            end
            default: state_n = ball_pkg::ST_IDLE;
        endcase
    end

    always_comb begin
        hit = ({1'b0, xCount} >= {1'b0, ballX})
           && ({1'b0, xCount} <= ({1'b0, ballX} + SPAN))
           && ({1'b0, yCount} >= {2'b00, ballY})
           && ({1'b0, yCount} <= ({2'b00, ballY} + SPAN));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= ball_pkg::ST_IDLE;
            ballX    <= START_X;
            y        <= {2'b00, GROUND_Y};
            vx       <= 5'd0;
            vy       <= 8'sd0;
            launch_q <= 1'b1;
            ball     <= 1'b0;
        end else begin
            state    <= state_n;
            ballX    <= x_n;
            y        <= y_n;
            vx       <= vx_n;
            vy       <= vy_n;
            launch_q <= launch;
            ball     <= hit;
        end
    end

endmodule

// File: doc/ball_flight.md
BALL_FLIGHT -- requirements
Module: ball_flight

Interface
REQ-001 SHALL have parameter START_X, default 10'd31, ball launch column and idle X position.
REQ-002 SHALL have parameter GROUND_Y, default 9'd425, ground row; launch row and landing row.
REQ-003 SHALL have parameter RIGHT_X, default 10'd635, right wall column where flight stops.
REQ-004 SHALL have ports: clk  in  1  system clock; rst  in  1  synchronous active-low reset.
REQ-005 SHALL have ports: launch  in  1  active-low fire button, already debounced; update  in  1  one-clk frame-tick pulse.
REQ-006 SHALL have ports: Vel  in  3  power 0..5; Ang  in  5  angle step 0..16, from the aiming stage.
REQ-007 SHALL have ports: xCount  in  10  and yCount  in  10, the current VGA pixel coordinates.
REQ-008 SHALL have ports: ballX  out  10  and ballY  out  9, the ball's top-left position.
REQ-009 SHALL have ports: ball  out  1  pixel-hit; busy  out  1  in flight; landed  out  1  flight finished.

Function
REQ-010 SHALL implement states IDLE, FLIGHT and LANDED; only transitions named here are legal.
REQ-011 SHALL register launch into launch_q; press = launch_q & ~launch, a falling edge.
REQ-012 IDLE: on press, SHALL latch vx, vy from Vel/Ang, set position (START_X, GROUND_Y) and enter FLIGHT next clk.
REQ-013 SHALL compute vx = (COS[Ang]*(Vel+1))>>2 and vy = (SIN[Ang]*(Vel+1))>>2; both are unsigned 5-bit at latch.
REQ-014 SHALL define SIN[a] = round(15*sin(a*5.625 deg)) and COS[a] = round(15*cos(a*5.625 deg)), a = 0..16, 4-bit; Ang > 16 is treated as 16.
REQ-015 FLIGHT: on each update pulse, SHALL set x += vx, y -= vy and vy -= 1, all in one clk; vy is signed 8-bit and y is signed 11-bit internally.
REQ-016 FLIGHT: if new y >= GROUND_Y, SHALL clamp y = GROUND_Y and enter LANDED on that same update.
REQ-017 FLIGHT: if new x >= RIGHT_X, SHALL clamp x = RIGHT_X and enter LANDED; a simultaneous ground hit clamps both.
REQ-018 FLIGHT: SHALL ignore press, and Vel/Ang changes SHALL NOT affect the flight in progress.
REQ-019 LANDED: SHALL hold position; on press, SHALL relaunch exactly as in IDLE.
REQ-020 In IDLE, SHALL hold ballX = START_X and ballY = GROUND_Y.
REQ-021 update coincident with press in IDLE/LANDED: SHALL launch only; first motion occurs on the next update pulse.
REQ-022 Outputs: busy = (FLIGHT), landed = (LANDED), both registered with the state.
REQ-023 ball SHALL be registered: 1 when xCount in [ballX, ballX+4] and yCount in [ballY, ballY+4]; it has 1-clk latency and is visible in every state.

Reset
REQ-024 When rst = 0 at a clk edge, SHALL set state = IDLE, ballX = START_X, ballY = GROUND_Y, vx = vy = 0, launch_q = 1, ball = busy = landed = 0.
REQ-025 Reset mid-flight SHALL abort the flight within one clk; no further motion occurs until a new press after release.

Structure
REQ-026 Shared package ball_pkg SHALL hold the state encoding, START_X, GROUND_Y, RIGHT_X, BALL_SIZE = 5 and the 17-entry SIN/COS tables.
REQ-027 SHALL instantiate one sub-module, launch_vector: combinational Ang/Vel -> vx, vy, using the tables.

Verification
REQ-028 Reset then release: ballX = 31, ballY = 425, busy = 0, landed = 0; xCount = 33, yCount = 427 gives ball = 1 one clk later.
REQ-029 Ang = 0, Vel = 3, press, one update: vx = 15, vy = 0 -> ballX = 46, ballY = 425, landed = 1, busy = 0.
REQ-030 Ang = 16, Vel = 5, press: vx = 0, vy = 22 -> after update 1 ballY = 403; after 22 updates ballY = 172; after 45 updates ballY = 425, landed = 1.
REQ-031 Ang = 8, Vel = 5 (vx = vy = 16), press, then change Ang = 0 and press again mid-flight: trajectory unchanged, landed after update 33 at ballX = 559.
REQ-032 Press with update in the same clk: no motion that clk; first update after it moves the ball. Holding launch low after landing gives no relaunch until released and pressed again.
REQ-033 Ang = 16, Vel = 5, drive rst = 0 after 10 updates: next clk ballX = 31, ballY = 425, busy = 0, and the ball stays there across subsequent updates.
